// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, bubble encoding, fetch FSM states.
// Pure declarations; no latency or flow control of its own.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // sll $0,$0,0 -- decodes as R-type with no architectural effect
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Redirect detect and target priority mux: EX branch > ID jr > ID j/jal.
// Combinational; stalled ID redirects are masked so ID can re-present them.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic        stall,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        id_jr,
  input  logic [31:0] id_jr_target,
  input  logic        id_jump,
  input  logic [25:0] id_jump_index,
  input  logic [3:0]  pc_region,
  output logic        redir,
  output logic [31:0] target
);

  logic [31:0] raw_target;

  always_comb begin
    redir = ex_branch_taken | (!stall & (id_jr | id_jump));
    raw_target = jump_target(pc_region, id_jump_index);
    if (ex_branch_taken) begin
      raw_target = ex_branch_target;
    end else if (id_jr) begin
      raw_target = id_jr_target;
    end
    target = raw_target & ~32'h0000_0003;
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// Fetch stage: PC, imem req/ack fetch FSM and IF/ID register; ack in cycle N shows on ifid_* in N+1.
// Stall parks an acked word in S_HOLD with imem_req low; redirects mid-fetch drain the old request first.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        id_jr,
  input  logic [31:0] id_jr_target,
  input  logic        id_jump,
  input  logic [25:0] id_jump_index,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  pend_pc, pend_pc_d;
  logic [31:0]  hold_instr, hold_instr_d;
  logic         ifid_valid_d;
  logic [31:0]  ifid_instr_d, ifid_pc4_d;
  logic         redir;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         ack;
  logic         deliver;
  logic [31:0]  deliver_instr;

  mips_next_pc u_next_pc (
    .stall            (stall),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .id_jr            (id_jr),
    .id_jr_target     (id_jr_target),
    .id_jump          (id_jump),
    .id_jump_index    (id_jump_index),
    .pc_region        (ifid_pc4[31:28]),
    .redir            (redir),
    .target           (target)
  );

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = !rst && ((state == S_REQ) || (state == S_DRAIN));
  assign ack       = imem_ack && imem_req;

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    pend_pc_d     = pend_pc;
    hold_instr_d  = hold_instr;
    deliver       = 1'b0;
    deliver_instr = hold_instr;
    case (state)
      S_REQ: begin
        if (ack) begin
          if (redir) begin
            pc_d = target;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_d          = pc_plus4;
          end
        end else if (redir) begin
          // Request stays up; imem must still complete it before we move on
          pend_pc_d = target;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ack) begin
          pc_d    = redir ? target : pend_pc;
          state_d = S_REQ;
        end else if (redir) begin
          pend_pc_d = target;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    ifid_valid_d = 1'b0;
    ifid_instr_d = NOP_INSTR;
    ifid_pc4_d   = ifid_pc4;
    if (redir) begin
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      ifid_valid_d = ifid_valid;
      ifid_instr_d = ifid_instr;
    end else if (deliver) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = deliver_instr;
      ifid_pc4_d   = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      pend_pc    <= 32'h0;
      hold_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= 32'h0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pend_pc    <= pend_pc_d;
      hold_instr <= hold_instr_d;
      ifid_valid <= ifid_valid_d;
      ifid_instr <= ifid_instr_d;
      ifid_pc4   <= ifid_pc4_d;
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage; imem returns addr ^ 32'h2000_0000 as the instruction word.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        id_jr;
  logic [31:0] id_jr_target;
  logic        id_jump;
  logic [25:0] id_jump_index;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'h2000_0000;

  mips_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .id_jr            (id_jr),
    .id_jr_target     (id_jr_target),
    .id_jump          (id_jump),
    .id_jump_index    (id_jump_index),
    .ifid_valid       (ifid_valid),
    .ifid_instr       (ifid_instr),
    .ifid_pc4         (ifid_pc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    id_jr = 1'b0; id_jr_target = 32'h0; id_jump = 1'b0; id_jump_index = 26'h0;
    next_cycle();
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    next_cycle();

    // 1) 0-wait sequential fetch
    rst = 1'b0; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_req", {31'b0, imem_req}, 32'h1);
      chk("t1_valid", {31'b0, ifid_valid}, (i == 0) ? 32'h0 : 32'h1);
      if (i > 0) begin
        chk("t1_instr", ifid_instr, 32'(4 * (i - 1)) ^ 32'h2000_0000);
        chk("t1_pc4", ifid_pc4, 32'(4 * i));
      end
      next_cycle();
    end

    // 2) slow ack with a branch during the wait
    imem_ack = 1'b0;
    @(negedge clk);
    chk("t1_last_instr", ifid_instr, 32'h2000_000C);
    chk("t1_last_pc4", ifid_pc4, 32'h10);
    chk("t2_addr_w0", imem_addr, 32'h10);
    next_cycle();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h40;
    @(negedge clk);
    chk("t2_addr_w1", imem_addr, 32'h10);
    chk("t2_valid_w1", {31'b0, ifid_valid}, 32'h0);
    next_cycle();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    chk("t2_addr_w2", imem_addr, 32'h10);
    chk("t2_req_w2", {31'b0, imem_req}, 32'h1);
    chk("t2_valid_w2", {31'b0, ifid_valid}, 32'h0);
    next_cycle();
    imem_ack = 1'b1;
    @(negedge clk);
    chk("t2_addr_ack", imem_addr, 32'h10);
    next_cycle();
    @(negedge clk);
    chk("t2_redir_addr", imem_addr, 32'h40);
    chk("t2_no_wrong_path", {31'b0, ifid_valid}, 32'h0);
    next_cycle();

    // 3) stall on the ack cycle for 4 cycles
    stall = 1'b1;
    @(negedge clk);
    chk("t3_pre_instr", ifid_instr, 32'h2000_0040);
    chk("t3_pre_pc4", ifid_pc4, 32'h44);
    chk("t3_pre_addr", imem_addr, 32'h44);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_req_off", {31'b0, imem_req}, 32'h0);
      chk("t3_frozen_valid", {31'b0, ifid_valid}, 32'h1);
      chk("t3_frozen_instr", ifid_instr, 32'h2000_0040);
      chk("t3_frozen_pc4", ifid_pc4, 32'h44);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t3_rel_req", {31'b0, imem_req}, 32'h0);
    chk("t3_rel_instr", ifid_instr, 32'h2000_0040);
    next_cycle();
    imem_ack = 1'b0;
    @(negedge clk);
    chk("t3_held_valid", {31'b0, ifid_valid}, 32'h1);
    chk("t3_held_instr", ifid_instr, 32'h2000_0044);
    chk("t3_held_pc4", ifid_pc4, 32'h48);
    chk("t3_next_addr", imem_addr, 32'h48);
    next_cycle();

    // 4) j from ifid_pc4 0x1000_0010, then the same with stall
    imem_ack = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h1000_000C;
    @(negedge clk);
    chk("t3_once", {31'b0, ifid_valid}, 32'h0);
    next_cycle();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    chk("t4_setup_addr", imem_addr, 32'h1000_000C);
    next_cycle();
    id_jump = 1'b1; id_jump_index = 26'h0000100;
    @(negedge clk);
    chk("t4_jump_pc4", ifid_pc4, 32'h1000_0010);
    chk("t4_jump_valid", {31'b0, ifid_valid}, 32'h1);
    next_cycle();
    id_jump = 1'b0;
    @(negedge clk);
    chk("t4_jump_addr", imem_addr, 32'h1000_0400);
    chk("t4_bubble", {31'b0, ifid_valid}, 32'h0);
    next_cycle();
    id_jump = 1'b1; id_jump_index = 26'h0000200; stall = 1'b1;
    @(negedge clk);
    chk("t4_tgt_instr", ifid_instr, 32'h3000_0400);
    chk("t4_tgt_pc4", ifid_pc4, 32'h1000_0404);
    next_cycle();
    id_jump = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("t4_stall_req", {31'b0, imem_req}, 32'h0);
    next_cycle();

    // 5) priority: branch beats jr and jump; redirect beats stall
    ex_branch_taken = 1'b1; ex_branch_target = 32'h80;
    id_jr = 1'b1; id_jr_target = 32'h90; id_jump = 1'b1; id_jump_index = 26'h3;
    @(negedge clk);
    chk("t4_ignored_addr", imem_addr, 32'h1000_0408);
    chk("t4_ignored_instr", ifid_instr, 32'h3000_0404);
    chk("t4_ignored_pc4", ifid_pc4, 32'h1000_0408);
    next_cycle();
    ex_branch_taken = 1'b0; id_jr = 1'b0; id_jump = 1'b0;
    @(negedge clk);
    chk("t5_prio_addr", imem_addr, 32'h80);
    chk("t5_prio_bubble", {31'b0, ifid_valid}, 32'h0);
    next_cycle();
    stall = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h100;
    @(negedge clk);
    chk("t5_pre_instr", ifid_instr, 32'h2000_0080);
    next_cycle();
    stall = 1'b0; ex_branch_taken = 1'b0; id_jr = 1'b1; id_jr_target = 32'h0000_0123;
    @(negedge clk);
    chk("t5_stall_bubble", {31'b0, ifid_valid}, 32'h0);
    chk("t5_stall_nop", ifid_instr, 32'h0);
    chk("t5_stall_addr", imem_addr, 32'h100);
    next_cycle();

    // 6) jr target alignment, PC wrap, reset while draining
    id_jr = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("t5_jr_addr", imem_addr, 32'h120);
    next_cycle();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    imem_ack = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'h200;
    @(negedge clk);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    chk("t6_wrap_instr", ifid_instr, 32'hDFFF_FFFC);
    chk("t6_wrap_pc4", ifid_pc4, 32'h0);
    next_cycle();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    chk("t6_drain_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_req_comb", {31'b0, imem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t6_rst_req", {31'b0, imem_req}, 32'h0);
    chk("t6_rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("t6_rst_instr", ifid_instr, 32'h0);
    chk("t6_rst_pc4", ifid_pc4, 32'h0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    next_cycle();
    rst = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    chk("t6_post_req", {31'b0, imem_req}, 32'h1);
    chk("t6_post_addr", imem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("t6_post_next", imem_addr, 32'h4);
    chk("t6_post_instr", ifid_instr, 32'h2000_0000);
    chk("t6_post_pc4", ifid_pc4, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
